// File: rtl/qracc_pingpong_feature_loader.sv
// Ping-pong activation loader: buffer words fill one bank while seq_acc consumes the masked vector in the other.
// Vector valid the cycle after its commit edge; wr_ready_o drops with both banks committed, data_o holds while !ready_i.
module qracc_pingpong_feature_loader #(
  parameter int inputWidth   = 256,
  parameter int elementWidth = 8,
  parameter int numElements  = 128,
  parameter int maxReuse     = 16,
  localparam int ElemsPerWord   = inputWidth / elementWidth,
  localparam int WordsPerVector = numElements / ElemsPerWord,
  localparam int AddrW          = $clog2(WordsPerVector) + 1,
  localparam int MaskW          = $clog2(numElements + 1),
  localparam int ReuseW         = (maxReuse > 1) ? $clog2(maxReuse) : 1
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                clear_i,
  input  logic                                wr_en_i,
  input  logic [AddrW-1:0]                    wr_addr_i,
  input  logic [inputWidth-1:0]               wr_data_i,
  input  logic                                wr_last_i,
  output logic                                wr_ready_o,
  input  logic [MaskW-1:0]                    mask_start_i,
  input  logic [MaskW-1:0]                    mask_end_i,
  input  logic [ReuseW-1:0]                   reuse_i,
  output logic [numElements*elementWidth-1:0] data_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [1:0]                          occupancy_o,
  output logic                                err_o
);

  localparam int IdxW = (WordsPerVector > 1) ? $clog2(WordsPerVector) : 1;

  if ((inputWidth % elementWidth != 0) || (numElements % ElemsPerWord != 0) || (WordsPerVector < 1))
  begin : g_bad_geometry
    $error("numElements must be a whole, nonzero number of buffer words");
  end

  logic [inputWidth-1:0] bank_q [2][WordsPerVector];
  logic                  fill_ptr_q, fill_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic [ReuseW-1:0]     rcnt_q, rcnt_d;
  logic                  err_q, err_d;

  logic             addr_ok;
  logic             wr_acc;
  logic             commit;
  logic             fire;
  logic             pop;
  logic [IdxW-1:0]  wr_idx;

  assign wr_ready_o  = (occ_q != 2'd2);
  assign valid_o     = (occ_q != 2'd0);
  assign occupancy_o = occ_q;
  assign err_o       = err_q;

  assign addr_ok = (wr_addr_i < AddrW'(WordsPerVector));
  assign wr_idx  = wr_addr_i[IdxW-1:0];
  assign wr_acc  = wr_en_i & wr_ready_o & addr_ok & ~clear_i;
  assign commit  = wr_acc & wr_last_i;
  assign fire    = valid_o & ready_i & ~clear_i;
  // >= keeps the counter bounded even if reuse_i is lowered mid-vector.
  assign pop     = fire & (rcnt_q >= reuse_i);

  always_comb begin
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    rcnt_d     = rcnt_q;
    err_d      = err_q;
    if (clear_i) begin
      fill_ptr_d = 1'b0;
      rd_ptr_d   = 1'b0;
      occ_d      = 2'd0;
      rcnt_d     = '0;
      err_d      = 1'b0;
    end else begin
      if (wr_en_i && (!wr_ready_o || !addr_ok)) err_d = 1'b1;
      if (commit) fill_ptr_d = ~fill_ptr_q;
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        rcnt_d   = '0;
      end else if (fire) begin
        rcnt_d = rcnt_q + ReuseW'(1);
      end
      occ_d = occ_q + {1'b0, commit} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fill_ptr_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      rcnt_q     <= '0;
      err_q      <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < WordsPerVector; w++) begin
          bank_q[b][w] <= '0;
        end
      end
    end else begin
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rcnt_q     <= rcnt_d;
      err_q      <= err_d;
      if (wr_acc) bank_q[fill_ptr_q][wr_idx] <= wr_data_i;
    end
  end

  for (genvar i = 0; i < numElements; i++) begin : g_elem
    localparam int WordIdx = i / ElemsPerWord;
    localparam int ByteIdx = i % ElemsPerWord;
    logic in_mask;
    assign in_mask = (MaskW'(i) >= mask_start_i) && (MaskW'(i) < mask_end_i);
    assign data_o[i*elementWidth +: elementWidth] =
      in_mask ? bank_q[rd_ptr_q][WordIdx][ByteIdx*elementWidth +: elementWidth] : '0;
  end

endmodule
